// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter: round-robin arbiter that shares one I2C write engine among N requesters.
// Latches the winner's operands, launches the engine, and returns a done/err pulse under a watchdog.
module i2c_write_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [7*N-1:0] req_addr,
   input  logic [8*N-1:0] req_data,
   input  logic [8*N-1:0] req_data2,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   done,
   output logic [N-1:0]   err,
   output logic           idle,
   output logic           eng_start,
   output logic [6:0]     eng_addr,
   output logic [7:0]     eng_data,
   output logic [7:0]     eng_data2,
   input  logic           eng_busy,
   input  logic           eng_done
);

   localparam int unsigned   PW         = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned   TW         = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] LAST_IDX   = PW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_COMPLETE
   } state_t;

   state_t        state_q;
   logic [N-1:0]  gnt_q;
   logic [N-1:0]  done_q;
   logic [N-1:0]  err_q;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] g_q;
   logic [TW-1:0] timer_q;
   logic [6:0]    addr_q;
   logic [7:0]    data_q;
   logic [7:0]    data2_q;

   logic          win_found;
   logic [PW-1:0] win_idx;
   logic [6:0]    win_addr;
   logic [7:0]    win_data;
   logic [7:0]    win_data2;
   int unsigned   cand;

   // Search starts at ptr and wraps, so the first hit is the round-robin winner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < N; i++) begin
         cand = (32'(ptr_q) + i) % N;
         if (!win_found && req[cand[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PW-1:0];
         end
      end
      win_addr  = '0;
      win_data  = '0;
      win_data2 = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (win_idx == PW'(i)) begin
            win_addr  = req_addr[7*i +: 7];
            win_data  = req_data[8*i +: 8];
            win_data2 = req_data2[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         err_q   <= '0;
         ptr_q   <= '0;
         g_q     <= '0;
         timer_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         data2_q <= '0;
      end else begin
         done_q <= '0;
         err_q  <= '0;
         case (state_q)
            S_IDLE: begin
               if (win_found) begin
                  gnt_q   <= N'(1) << win_idx;
                  g_q     <= win_idx;
                  addr_q  <= win_addr;
                  data_q  <= win_data;
                  data2_q <= win_data2;
                  state_q <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               if (!eng_busy) begin
                  timer_q <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               timer_q <= timer_q + 1'b1;
               // Engine completion takes priority over a watchdog expiry on the same cycle.
               if (eng_done) begin
                  done_q  <= gnt_q;
                  state_q <= S_COMPLETE;
               end else if (timer_q == TIMER_LAST) begin
                  done_q  <= gnt_q;
                  err_q   <= gnt_q;
                  state_q <= S_COMPLETE;
               end
            end
            S_COMPLETE: begin
               gnt_q   <= '0;
               ptr_q   <= (g_q == LAST_IDX) ? '0 : g_q + 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign err       = err_q;
   assign idle      = (state_q == S_IDLE);
   assign eng_start = (state_q == S_LAUNCH) && !eng_busy;
   assign eng_addr  = addr_q;
   assign eng_data  = data_q;
   assign eng_data2 = data2_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Bench for i2c_write_arbiter: table of arbitration vectors plus hand sequences for
// busy hold-off, timeout, done/timeout tie and reset during WAIT.
module tb_i2c_write_arbiter;

   localparam int N  = 4;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [7*N-1:0] req_addr;
   logic [8*N-1:0] req_data;
   logic [8*N-1:0] req_data2;
   logic [N-1:0]  gnt, done, err;
   logic          idle, eng_start;
   logic [6:0]    eng_addr;
   logic [7:0]    eng_data, eng_data2;
   logic          eng_busy, eng_done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         g;
      logic [6:0] addr;
      logic [7:0] d1;
      logic [7:0] d2;
      logic       e;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [3:0] req;
      int         g;
      int         lat;
      int         busy;
      bit         drop;
   } vec_t;
   vec_t tbl[10];

   i2c_write_arbiter #(.N(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
      .req_data2(req_data2), .gnt(gnt), .done(done), .err(err), .idle(idle),
      .eng_start(eng_start), .eng_addr(eng_addr), .eng_data(eng_data),
      .eng_data2(eng_data2), .eng_busy(eng_busy), .eng_done(eng_done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic fill_ops(input int seed);
      for (int i = 0; i < N; i++) begin
         req_addr[i*7 +: 7]  = 7'((seed * 37 + i * 19 + 5) % 128);
         req_data[i*8 +: 8]  = 8'((seed * 53 + i * 71 + 3) % 256);
         req_data2[i*8 +: 8] = 8'((seed * 29 + i * 97 + 11) % 256);
      end
   endtask

   // lat < 0: engine never answers. busy: cycles eng_busy stays high after grant.
   task automatic run_txn(input string tag, input logic [3:0] reqv, input int g,
                          input int lat, input int busy, input bit drop);
      exp_t e, got;
      int cnt;
      int early;
      e.g    = g;
      e.addr = req_addr[g*7 +: 7];
      e.d1   = req_data[g*8 +: 8];
      e.d2   = req_data2[g*8 +: 8];
      e.e    = (lat < 0);
      e.cyc  = (lat < 0) ? TO : lat + 1;
      sb.push_back(e);

      req      = reqv;
      eng_busy = (busy > 0);
      tick;
      chk({tag, "_gnt"}, 32'(gnt), 32'(1) << g);
      chk({tag, "_idle_low"}, 32'(idle), 0);
      early = 0;
      for (int b = 0; b < busy; b++) begin
         if (eng_start !== 1'b0) early++;
         tick;
      end
      if (busy > 0) chk({tag, "_start_while_busy"}, early, 0);
      eng_busy = 1'b0;
      #1;
      chk({tag, "_start"}, 32'(eng_start), 1);
      chk({tag, "_addr"}, 32'(eng_addr), 32'(sb[0].addr));
      chk({tag, "_data"}, 32'(eng_data), 32'(sb[0].d1));
      chk({tag, "_data2"}, 32'(eng_data2), 32'(sb[0].d2));
      req_addr  = ~req_addr;
      req_data  = ~req_data;
      req_data2 = ~req_data2;
      if (drop) req = reqv & ~(4'b0001 << g);
      tick;
      chk({tag, "_start_once"}, 32'(eng_start), 0);

      cnt = 0;
      while (done === '0 && cnt < 200) begin
         eng_done = (cnt == lat);
         tick;
         cnt++;
      end
      eng_done = 1'b0;
      got = sb.pop_front();
      chk({tag, "_wait_cycles"}, cnt, got.cyc);
      chk({tag, "_done"}, 32'(done), 32'(1) << got.g);
      chk({tag, "_err"}, 32'(err), got.e ? (32'(1) << got.g) : 0);
      chk({tag, "_addr_held"}, 32'(eng_addr), 32'(got.addr));
      chk({tag, "_data_held"}, 32'(eng_data), 32'(got.d1));
      chk({tag, "_data2_held"}, 32'(eng_data2), 32'(got.d2));

      req = '0;
      tick;
      chk({tag, "_done_clr"}, 32'(done), 0);
      chk({tag, "_err_clr"}, 32'(err), 0);
      chk({tag, "_idle_back"}, 32'(idle), 1);
      chk({tag, "_gnt_clr"}, 32'(gnt), 0);
   endtask

   initial begin
      tbl[0] = '{4'b1111, 0, 0, 0, 1'b0};
      tbl[1] = '{4'b1111, 1, 2, 0, 1'b0};
      tbl[2] = '{4'b1111, 2, 5, 1, 1'b0};
      tbl[3] = '{4'b1111, 3, 1, 0, 1'b0};
      tbl[4] = '{4'b1111, 0, 3, 2, 1'b0};
      tbl[5] = '{4'b0011, 1, 0, 0, 1'b0};
      tbl[6] = '{4'b1001, 3, 4, 0, 1'b0};
      tbl[7] = '{4'b0110, 1, 2, 0, 1'b1};
      tbl[8] = '{4'b0100, 2, 1, 0, 1'b0};
      tbl[9] = '{4'b0011, 0, 6, 0, 1'b0};

      rst       = 1'b0;
      req       = '0;
      req_addr  = '0;
      req_data  = '0;
      req_data2 = '0;
      eng_busy  = 1'b0;
      eng_done  = 1'b0;
      tick;
      tick;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_start", 32'(eng_start), 0);
      chk("rst_addr", 32'(eng_addr), 0);
      chk("rst_data", 32'(eng_data), 0);
      chk("rst_data2", 32'(eng_data2), 0);
      chk("rst_idle", 32'(idle), 1);
      rst = 1'b1;
      tick;

      for (int v = 0; v < 10; v++) begin
         fill_ops(v + 1);
         run_txn($sformatf("vec%0d", v), tbl[v].req, tbl[v].g, tbl[v].lat,
                 tbl[v].busy, tbl[v].drop);
      end

      fill_ops(20);
      req_addr[2*7 +: 7]  = 7'h50;
      req_data[2*8 +: 8]  = 8'hA5;
      req_data2[2*8 +: 8] = 8'h3C;
      run_txn("single", 4'b0100, 2, 20, 0, 1'b0);

      fill_ops(21);
      run_txn("busy", 4'b0001, 0, 4, 10, 1'b0);

      fill_ops(22);
      run_txn("timeout", 4'b0010, 1, -1, 0, 1'b0);

      fill_ops(23);
      run_txn("tie", 4'b0100, 2, TO - 1, 0, 1'b0);

      fill_ops(24);
      req = 4'b1000;
      tick;
      tick;
      tick;
      tick;
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_idle", 32'(idle), 1);
      chk("mid_rst_start", 32'(eng_start), 0);
      chk("mid_rst_addr", 32'(eng_addr), 0);
      @(posedge clk);
      #1;
      rst      = 1'b1;
      req      = '0;
      eng_done = 1'b1;
      tick;
      eng_done = 1'b0;
      chk("stale_done", 32'(done), 0);
      chk("stale_err", 32'(err), 0);
      chk("stale_idle", 32'(idle), 1);
      tick;
      chk("stale_idle2", 32'(idle), 1);
      fill_ops(25);
      run_txn("after_rst", 4'b1111, 0, 2, 3, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
